// File: rtl/qam_symbol_framer_pkg.sv
// Shared types and constants for the QAM symbol framer (package qam_pkg).
package qam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA
  } state_t;

  localparam logic [1:0] SYM_IDLE     = 2'b00;
  localparam logic [1:0] PRE_A        = 2'b11;
  localparam logic [1:0] PRE_B        = 2'b00;
  localparam int         BITS_PER_SYM = 2;

endpackage

// File: rtl/qam_symbol_framer_fifo.sv
// Byte FIFO with first-word-fall-through read data and an occupancy count.
module qam_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  // Guard against over/underflow even if a caller misbehaves.
  assign do_push = push && (level != LW'(DEPTH));
  assign do_pop  = pop && (level != '0);
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/qam_symbol_framer.sv
// Slices buffered payload bytes into 2-bit QAM symbols held for SYM_CLKS clocks.
// QAM_FRAMER_PREAMBLE_EN adds an alternating 11/00 preamble ahead of each burst.
import qam_pkg::*;

module qam_symbol_framer #(
  parameter int SYM_CLKS      = 16,
  parameter int PREAMBLE_SYMS = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [1:0]                    sym_out,
  output logic                          sym_strobe,
  output logic                          tx_en,
  output logic                          carrier_sync,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam int CW    = $clog2(SYM_CLKS);
  localparam int SLOTS = 8 / BITS_PER_SYM;

  if (SYM_CLKS < 2 || PREAMBLE_SYMS < 1 || FIFO_DEPTH < 2) begin : g_bad_param
    $error("qam_symbol_framer: illegal parameter value");
  end

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      sidx;
  logic [7:0]      sh;
  logic [7:0]      rd_data;
  logic            push, pop, sym_last, slot_last, have_byte;

`ifdef QAM_FRAMER_PREAMBLE_EN
  localparam int PW = $clog2(PREAMBLE_SYMS) + 1;
  logic [PW-1:0]   pre_idx;
`endif

  assign in_ready  = !rst && (fifo_level != LW'(FIFO_DEPTH));
  assign push      = in_valid && in_ready;
  assign have_byte = (fifo_level != '0);
  assign sym_last  = (cnt == CW'(SYM_CLKS - 1));
  assign slot_last = (sidx == 2'(SLOTS - 1));

  qam_byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (rd_data),
    .level   (fifo_level)
  );

  // Pops only ever happen on a symbol-boundary edge (or the burst-start edge without preamble).
  always_comb begin
    pop = 1'b0;
    case (state)
`ifdef QAM_FRAMER_PREAMBLE_EN
      ST_PREAMBLE: pop = sym_last && (pre_idx == PW'(PREAMBLE_SYMS - 1));
`else
      ST_IDLE:     pop = have_byte;
`endif
      ST_DATA:     pop = sym_last && slot_last && have_byte;
      default:     pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      sidx         <= '0;
      sh           <= '0;
      sym_out      <= SYM_IDLE;
      sym_strobe   <= 1'b0;
      tx_en        <= 1'b0;
      carrier_sync <= 1'b0;
`ifdef QAM_FRAMER_PREAMBLE_EN
      pre_idx      <= '0;
`endif
    end else begin
      carrier_sync <= 1'b0;
      sym_strobe   <= 1'b0;
      if (state != ST_IDLE) begin
        cnt        <= sym_last ? '0 : cnt + 1'b1;
        sym_strobe <= sym_last;
      end
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (have_byte) begin
            carrier_sync <= 1'b1;
            sym_strobe   <= 1'b1;
            tx_en        <= 1'b1;
`ifdef QAM_FRAMER_PREAMBLE_EN
            state        <= ST_PREAMBLE;
            pre_idx      <= '0;
            sym_out      <= PRE_A;
`else
            state        <= ST_DATA;
            sh           <= rd_data;
            sym_out      <= rd_data[7 -: BITS_PER_SYM];
            sidx         <= '0;
`endif
          end
        end
`ifdef QAM_FRAMER_PREAMBLE_EN
        ST_PREAMBLE: begin
          if (sym_last) begin
            if (pop) begin
              state   <= ST_DATA;
              sh      <= rd_data;
              sym_out <= rd_data[7 -: BITS_PER_SYM];
              sidx    <= '0;
            end else begin
              pre_idx <= pre_idx + 1'b1;
              sym_out <= pre_idx[0] ? PRE_A : PRE_B;
            end
          end
        end
`endif
        ST_DATA: begin
          if (sym_last) begin
            if (!slot_last) begin
              sidx    <= sidx + 1'b1;
              sh      <= sh << BITS_PER_SYM;
              sym_out <= sh[7-BITS_PER_SYM -: BITS_PER_SYM];
            end else if (pop) begin
              sh      <= rd_data;
              sym_out <= rd_data[7 -: BITS_PER_SYM];
              sidx    <= '0;
            end else begin
              state      <= ST_IDLE;
              tx_en      <= 1'b0;
              sym_out    <= SYM_IDLE;
              sym_strobe <= 1'b0;
              cnt        <= '0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qam_symbol_framer.sv
// Scoreboard bench for qam_symbol_framer; expected symbols are queued as bytes are accepted.
module tb_qam_symbol_framer;

  localparam int SYM_CLKS = 4;
  localparam int PRE_SYMS = 4;
  localparam int DEPTH    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] sym_out;
  logic       sym_strobe, tx_en, carrier_sync;
  logic [$clog2(DEPTH):0] fifo_level;

  int n_cmp = 0;
  int n_err = 0;
  int strobes = 0;
  int syncs = 0;
  logic [1:0] sb[$];

  qam_symbol_framer #(.SYM_CLKS(SYM_CLKS), .PREAMBLE_SYMS(PRE_SYMS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sym_out(sym_out), .sym_strobe(sym_strobe), .tx_en(tx_en),
    .carrier_sync(carrier_sync), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Scoreboard and per-cycle protocol monitor.
  int  gap = 0;
  bit  gap_ok = 1'b0;
  always @(negedge clk) begin
    if (carrier_sync) syncs++;
    if (!rst && !tx_en) begin
      n_cmp++;
      if (sym_out !== 2'b00 || sym_strobe !== 1'b0) begin
        n_err++;
        $display("FAIL idle_outputs: sym_out=%b strobe=%b, need 00/0", sym_out, sym_strobe);
      end
    end
    if (rst || !tx_en) gap_ok = 1'b0;
    else if (sym_strobe) begin
      if (gap_ok) begin
        n_cmp++;
        if (gap != SYM_CLKS) begin
          n_err++;
          $display("FAIL strobe_spacing: got %0d cycles, need %0d", gap, SYM_CLKS);
        end
      end
      gap = 1;
      gap_ok = 1'b1;
    end else gap++;
    if (sym_strobe && !rst) begin
      strobes++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL extra_symbol: got %b with nothing expected", sym_out);
      end else begin
        logic [1:0] e;
        e = sb.pop_front();
        if (sym_out !== e) begin
          n_err++;
          $display("FAIL symbol: got %b, need %b", sym_out, e);
        end
      end
    end
  end

  task automatic exp_preamble();
`ifdef QAM_FRAMER_PREAMBLE_EN
    for (int i = 0; i < PRE_SYMS; i++) sb.push_back((i % 2 == 0) ? 2'b11 : 2'b00);
`endif
  endtask

  // Offer one byte at a negedge, wait (bounded) for acceptance, queue its symbols.
  task automatic push_byte(input logic [7:0] b, input bit last, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    in_data = b;
    in_valid = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if (in_ready) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      waited++;
      @(negedge clk);
    end
    n_cmp++;
    if (!acc) begin
      n_err++;
      $display("FAIL push_timeout: byte %h not accepted, in_ready=%b", b, in_ready);
    end else begin
      sb.push_back(b[7:6]); sb.push_back(b[5:4]);
      sb.push_back(b[3:2]); sb.push_back(b[1:0]);
    end
    @(negedge clk);
    if (last) in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !tx_en) begin done = 1'b1; break; end
    end
    n_cmp++;
    if (!done || sym_out !== 2'b00 || fifo_level !== '0) begin
      n_err++;
      $display("FAIL %s_drain: done=%b left=%0d sym_out=%b level=%0d, need 1/0/00/0",
               name, done, sb.size(), sym_out, fifo_level);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || tx_en !== 1'b0 || sym_out !== 2'b00 || carrier_sync !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: ready=%b tx_en=%b sym=%b sync=%b, need 0/0/00/0",
               in_ready, tx_en, sym_out, carrier_sync);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || sym_out !== 2'b00 || tx_en !== 1'b0 || fifo_level !== '0 ||
          carrier_sync !== 1'b0 || sym_strobe !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle: ready=%b sym=%b tx_en=%b level=%0d, need 1/00/0/0",
                 in_ready, sym_out, tx_en, fifo_level);
      end
    end
  endtask

  task automatic test_single(input logic [7:0] b);
    int w, s0;
    logic [1:0] first;
    s0 = syncs;
    exp_preamble();
    push_byte(b, 1'b1, w);
    first = sb[0];
    @(negedge clk);
    n_cmp++;
    if (carrier_sync !== 1'b1 || sym_strobe !== 1'b1 || tx_en !== 1'b1 || sym_out !== first) begin
      n_err++;
      $display("FAIL single_start: sync=%b strobe=%b tx_en=%b sym=%b, need 1/1/1/%b",
               carrier_sync, sym_strobe, tx_en, sym_out, first);
    end
    @(negedge clk);
    n_cmp++;
    if (carrier_sync !== 1'b0) begin
      n_err++;
      $display("FAIL sync_width: sync=%b on second cycle, need 0", carrier_sync);
    end
    wait_idle("single");
    n_cmp++;
    if (syncs - s0 != 1) begin
      n_err++;
      $display("FAIL single_sync_count: got %0d, need 1", syncs - s0);
    end
  endtask

  task automatic test_back_to_back();
    int w, s0;
    s0 = syncs;
    exp_preamble();
    push_byte(8'hFF, 1'b0, w);
    push_byte(8'h00, 1'b0, w);
    push_byte(8'hA5, 1'b1, w);
    wait_idle("b2b");
    n_cmp++;
    if (syncs - s0 != 1) begin
      n_err++;
      $display("FAIL b2b_sync_count: got %0d, need 1", syncs - s0);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] bytes [6];
    int w, s0;
    bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    s0 = syncs;
    exp_preamble();
    for (int i = 0; i < 6; i++) begin
`ifdef QAM_FRAMER_PREAMBLE_EN
      if (i == 4) begin
        n_cmp++;
        if (in_ready !== 1'b0 || fifo_level !== 3'(DEPTH)) begin
          n_err++;
          $display("FAIL bp_full: ready=%b level=%0d, need 0/%0d", in_ready, fifo_level, DEPTH);
        end
      end
`endif
      push_byte(bytes[i], i == 5, w);
`ifdef QAM_FRAMER_PREAMBLE_EN
      if (i == 4) begin
        n_cmp++;
        if (w < 10) begin
          n_err++;
          $display("FAIL bp_wait: fifth byte waited %0d cycles, need >= 10", w);
        end
      end
`endif
    end
    wait_idle("bp");
    n_cmp++;
    if (syncs - s0 != 1) begin
      n_err++;
      $display("FAIL bp_sync_count: got %0d, need 1", syncs - s0);
    end
  endtask

  task automatic test_mid_reset();
    int w, target;
    bit hit;
    target = strobes;
    exp_preamble();
`ifdef QAM_FRAMER_PREAMBLE_EN
    target += PRE_SYMS + 2;
`else
    target += 2;
`endif
    push_byte(8'h3C, 1'b0, w);
    push_byte(8'h5A, 1'b1, w);
    hit = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk); #1;
      if (strobes >= target) begin hit = 1'b1; break; end
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL mid_reset_reach: strobes=%0d, need %0d", strobes, target);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    n_cmp++;
    if (sym_out !== 2'b00 || tx_en !== 1'b0 || fifo_level !== '0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: sym=%b tx_en=%b level=%0d ready=%b, need 00/0/0/0",
               sym_out, tx_en, fifo_level, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    test_single(8'hC9);
  endtask

  initial begin
    test_reset();
    test_single(8'hB4);
    test_single(8'h1B);
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
